// File: rtl/tinyqv_uart_fifo_if.sv
// Register-window bus of one tinyQV UART channel.
// The SoC decode side is the master; the UART instance is the slave.
interface tinyqv_uart_fifo_if;
  logic [1:0]  reg_sel;
  logic [1:0]  write_n;
  logic [1:0]  read_n;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output reg_sel, write_n, read_n, data_in, input data_out);
  modport slave  (input reg_sel, write_n, read_n, data_in, output data_out);
endinterface

// File: rtl/tinyqv_uart_fifo.sv
// tinyqv_uart_fifo: memory-mapped UART with TX/RX FIFOs, programmable baud
// divider, sticky overrun/framing flags and level interrupt.
// Optional feature macro: UART_RTS_EN (RTS flow control output).
// Register map: 0 DATA, 1 STATUS, 2 DIVIDER, 3 FLUSH.
module tinyqv_uart_fifo #(
  parameter int CLK_HZ        = 64_000_000,
  parameter int BIT_RATE      = 115_200,
  parameter int DIV_W         = 16,
  parameter int TX_DEPTH_LOG2 = 2,
  parameter int RX_DEPTH_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rstn,
  tinyqv_uart_fifo_if.slave bus,
  input  logic              uart_rxd,
  output logic              uart_txd,
  output logic              uart_rts,
  output logic              irq
);
  localparam int TX_DEPTH = 2 ** TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 2 ** RX_DEPTH_LOG2;
  localparam logic [DIV_W-1:0]       DIV_RST  = DIV_W'(CLK_HZ / BIT_RATE - 1);
  localparam logic [DIV_W-1:0]       DIV_MIN  = DIV_W'(3);
  localparam logic [TX_DEPTH_LOG2:0] TX_FULLC = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);
  localparam logic [RX_DEPTH_LOG2:0] RX_FULLC = (RX_DEPTH_LOG2 + 1)'(RX_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Bus decode
  logic w_wr, w_rd, w_wr_data, w_wr_stat, w_wr_div, w_tx_flush, w_rx_flush;
  logic w_unused_bits;
  assign w_wr       = (bus.write_n != 2'b11);
  assign w_rd       = (bus.read_n  != 2'b11);
  assign w_wr_data  = w_wr && (bus.reg_sel == 2'd0);
  assign w_wr_stat  = w_wr && (bus.reg_sel == 2'd1);
  assign w_wr_div   = w_wr && (bus.reg_sel == 2'd2);
  assign w_tx_flush = w_wr && (bus.reg_sel == 2'd3) && bus.data_in[0];
  assign w_rx_flush = w_wr && (bus.reg_sel == 2'd3) && bus.data_in[1];
  assign w_unused_bits = ^bus.data_in;

  logic [DIV_W-1:0] r_div, w_div_eff;
  logic             r_overrun, r_framing;
  // Small divider values cannot give a meaningful mid-bit sample point.
  assign w_div_eff = (r_div < DIV_MIN) ? DIV_MIN : r_div;

  // ---------------- TX FIFO + shifter ----------------
  logic [7:0]               r_tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] r_tx_wp, r_tx_rp;
  logic [TX_DEPTH_LOG2:0]   r_tx_cnt;
  logic [1:0]               r_tx_state;
  logic [DIV_W-1:0]         r_tx_baud;
  logic [2:0]               r_tx_bit;
  logic [7:0]               r_tx_shift;
  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_bit_end;

  assign w_tx_full    = (r_tx_cnt == TX_FULLC);
  assign w_tx_empty   = (r_tx_cnt == '0);
  assign w_tx_push    = w_wr_data && !w_tx_full;
  assign w_tx_bit_end = (r_tx_baud == '0);
  // Pop from IDLE, or straight out of STOP so frames run back-to-back.
  assign w_tx_pop = !w_tx_empty && !w_tx_flush &&
                    ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_bit_end));

  // TX storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.data_in[7:0];
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
    end else if (w_tx_flush) begin
      r_tx_rp <= r_tx_wp; r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  // TX framing FSM; the bit timer reloads from the divider only at boundaries
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_state <= S_IDLE; r_tx_baud <= '0; r_tx_bit <= '0; r_tx_shift <= '0;
    end else begin
      case (r_tx_state)
        S_IDLE: if (w_tx_pop) begin
          r_tx_shift <= r_tx_mem[r_tx_rp]; r_tx_baud <= w_div_eff; r_tx_state <= S_START;
        end
        S_START: if (w_tx_bit_end) begin
          r_tx_baud <= w_div_eff; r_tx_bit <= '0; r_tx_state <= S_DATA;
        end else r_tx_baud <= r_tx_baud - 1'b1;
        S_DATA: if (w_tx_bit_end) begin
          r_tx_baud  <= w_div_eff;
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          if (r_tx_bit == 3'd7) r_tx_state <= S_STOP;
          else r_tx_bit <= r_tx_bit + 1'b1;
        end else r_tx_baud <= r_tx_baud - 1'b1;
        default: if (w_tx_bit_end) begin
          if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rp]; r_tx_baud <= w_div_eff; r_tx_state <= S_START;
          end else r_tx_state <= S_IDLE;
        end else r_tx_baud <= r_tx_baud - 1'b1;
      endcase
    end
  end

  assign uart_txd = (r_tx_state == S_START) ? 1'b0 :
                    (r_tx_state == S_DATA)  ? r_tx_shift[0] : 1'b1;

  // ---------------- RX synchroniser + FSM + FIFO ----------------
  logic                     r_rx_s1, r_rx_s2, r_rx_prev;
  logic [1:0]               r_rx_state;
  logic [DIV_W-1:0]         r_rx_baud;
  logic [2:0]               r_rx_bit;
  logic [7:0]               r_rx_shift;
  logic [7:0]               r_rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] r_rx_wp, r_rx_rp;
  logic [RX_DEPTH_LOG2:0]   r_rx_cnt;
  logic w_rx_fall, w_rx_bit_end, w_rx_stop_end, w_rx_full, w_rx_empty;
  logic w_rx_pop, w_rx_push, w_rx_ovr_set, w_rx_frm_set;

  assign w_rx_fall     = r_rx_prev && !r_rx_s2;
  assign w_rx_bit_end  = (r_rx_baud == '0);
  assign w_rx_stop_end = (r_rx_state == S_STOP) && w_rx_bit_end;
  assign w_rx_full     = (r_rx_cnt == RX_FULLC);
  assign w_rx_empty    = (r_rx_cnt == '0);
  assign w_rx_pop      = w_rd && (bus.reg_sel == 2'd0) && !w_rx_empty;
  // A DATA read in the same cycle frees the slot a full FIFO needs.
  assign w_rx_push     = w_rx_stop_end && r_rx_s2 && (!w_rx_full || w_rx_pop) && !w_rx_flush;
  assign w_rx_ovr_set  = w_rx_stop_end && r_rx_s2 && w_rx_full && !w_rx_pop;
  assign w_rx_frm_set  = w_rx_stop_end && !r_rx_s2;

  // Two-flop synchroniser plus edge-detect history, idle-high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rxd; r_rx_s2 <= r_rx_s1; r_rx_prev <= r_rx_s2;
    end
  end

  // RX framing FSM: half-bit wait validates the start bit, then mid-bit samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_state <= S_IDLE; r_rx_baud <= '0; r_rx_bit <= '0; r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        S_IDLE: if (w_rx_fall) begin
          r_rx_baud <= w_div_eff >> 1; r_rx_state <= S_START;
        end
        S_START: if (w_rx_bit_end) begin
          if (r_rx_s2) r_rx_state <= S_IDLE;
          else begin
            r_rx_baud <= w_div_eff; r_rx_bit <= '0; r_rx_state <= S_DATA;
          end
        end else r_rx_baud <= r_rx_baud - 1'b1;
        S_DATA: if (w_rx_bit_end) begin
          r_rx_baud  <= w_div_eff;
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
          else r_rx_bit <= r_rx_bit + 1'b1;
        end else r_rx_baud <= r_rx_baud - 1'b1;
        default: if (w_rx_bit_end) r_rx_state <= S_IDLE;
                 else r_rx_baud <= r_rx_baud - 1'b1;
      endcase
    end
  end

  // RX storage array, written when a complete frame is accepted
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
    end else if (w_rx_flush) begin
      r_rx_rp <= r_rx_wp; r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
    end
  end

  // Divider register and sticky error flags (a new error beats a clear)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div <= DIV_RST; r_overrun <= 1'b0; r_framing <= 1'b0;
    end else begin
      if (w_wr_div) r_div <= bus.data_in[DIV_W-1:0];
      if (w_rx_ovr_set) r_overrun <= 1'b1;
      else if (w_wr_stat && bus.data_in[4]) r_overrun <= 1'b0;
      if (w_rx_frm_set) r_framing <= 1'b1;
      else if (w_wr_stat && bus.data_in[5]) r_framing <= 1'b0;
    end
  end

  // Combinational read mux
  always_comb begin
    bus.data_out = '0;
    case (bus.reg_sel)
      2'd0: bus.data_out = {w_rx_empty, 23'h0, r_rx_mem[r_rx_rp]};
      2'd1: bus.data_out = {26'h0, r_framing, r_overrun, w_rx_full, w_tx_full,
                            !w_rx_empty, !w_tx_empty || (r_tx_state != S_IDLE)};
      2'd2: bus.data_out = 32'(r_div);
      default: bus.data_out = '0;
    endcase
  end

  assign irq = !w_rx_empty || r_overrun || r_framing;

`ifdef UART_RTS_EN
  logic                   r_rts;
  logic [RX_DEPTH_LOG2:0] w_rx_free;
  assign w_rx_free = RX_FULLC - r_rx_cnt;
  // Ask the far end to stop while at most one RX slot remains
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rts <= 1'b0;
    else       r_rts <= (w_rx_free <= (RX_DEPTH_LOG2 + 1)'(1));
  end
  assign uart_rts = r_rts;
`else
  assign uart_rts = 1'b0;
`endif
endmodule

// File: tb/tb_tinyqv_uart_fifo.sv
// Testbench for tinyqv_uart_fifo: random TX/RX traffic against a queue-based
// reference model, a serial TX line decoder, and register/flag checks.
`timescale 1ns/1ps
module tb_tinyqv_uart_fifo;
  localparam int BITC = 4;          // clk cycles per bit with divider 3
  localparam int TXD  = 4;          // TX FIFO depth
  localparam int RXD  = 4;          // RX FIFO depth
`ifdef UART_RTS_EN
  localparam logic RTS_ON = 1'b1;
`else
  localparam logic RTS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rxd = 1'b1;
  logic txd, rts, irq;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  tinyqv_uart_fifo_if bus_if ();

  tinyqv_uart_fifo dut (
    .clk(clk), .rstn(rstn), .bus(bus_if),
    .uart_rxd(rxd), .uart_txd(txd), .uart_rts(rts), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_exp[$];
  logic [7:0] tx_seen[$];
  int         tx_start[$];
  logic       m_overrun = 1'b0;
  logic       m_framing = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {26'h0, m_framing, m_overrun, rx_q.size() == RXD, 1'b0, rx_q.size() != 0, 1'b0};
  endfunction

  task automatic bus_write(input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk);
    bus_if.reg_sel = sel;
    bus_if.data_in = d;
    bus_if.write_n = 2'($urandom_range(0, 2));
    @(negedge clk);
    bus_if.write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [31:0] d);
    @(negedge clk);
    bus_if.reg_sel = sel;
    bus_if.read_n  = 2'($urandom_range(0, 2));
    #1 d = bus_if.data_out;
    @(negedge clk);
    bus_if.read_n = 2'b11;
  endtask

  // Serial frame driver; updates the model by the receive rules
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 rxd = fr[k];
      repeat (BITC - 1) @(posedge clk);
    end
    @(posedge clk); #1 rxd = 1'b1;
    repeat (2 * BITC) @(posedge clk);
    if (!stop_ok) m_framing = 1'b1;
    else if (rx_q.size() < RXD) rx_q.push_back(b);
    else m_overrun = 1'b1;
  endtask

  task automatic wait_tx_idle(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      bus_read(2'd1, s);
      n++;
    end while (s[0] && n < 1000);
    check_val(tag, {31'h0, s[0]}, 32'h0);
  endtask

  task automatic check_tx(input string tag);
    check_val({tag, "_count"}, tx_seen.size(), tx_exp.size());
    for (int k = 0; k < tx_exp.size(); k++)
      check_val($sformatf("%s_byte%0d", tag, k),
                (k < tx_seen.size()) ? 32'(tx_seen[k]) : 32'hFFFF_FFFF, 32'(tx_exp[k]));
    tx_seen.delete(); tx_start.delete(); tx_exp.delete();
  endtask

  // TX line decoder: start detect, then mid-bit samples at BITC spacing
  logic [7:0] mon_b;
  int         mon_t0;
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (rstn && txd === 1'b0) begin
        mon_t0 = cyc;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (BITC) @(negedge clk);
          mon_b[k] = txd;
        end
        repeat (BITC) @(negedge clk);
        check_val("tx_stop_bit", {31'h0, txd}, 32'h1);
        tx_seen.push_back(mon_b);
        tx_start.push_back(mon_t0);
      end
    end
  end

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] d;
    logic [7:0]  b;
    bus_if.reg_sel = 2'd0;
    bus_if.write_n = 2'b11;
    bus_if.read_n  = 2'b11;
    bus_if.data_in = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_txd", {31'h0, txd}, 32'h1);
    check_val("rst_irq", {31'h0, irq}, 32'h0);
    check_val("rst_rts", {31'h0, rts}, 32'h0);
    rstn = 1'b1;
    bus_read(2'd2, d); check_val("rst_divider", d, 32'd554);
    bus_read(2'd1, d); check_val("rst_status", d, 32'h0);
    bus_read(2'd3, d); check_val("flush_reads_zero", d, 32'h0);
    bus_write(2'd2, 32'd3);
    bus_read(2'd2, d); check_val("divider_rw", d, 32'd3);

    // Back-to-back TX of 0x55, 0xA3
    bus_write(2'd0, 32'h55); tx_exp.push_back(8'h55);
    bus_write(2'd0, 32'hA3); tx_exp.push_back(8'hA3);
    bus_read(2'd1, d); check_val("tx_busy_on", {31'h0, d[0]}, 32'h1);
    wait_tx_idle("tx_idle_pair");
    check_val("tx_b2b_gap", (tx_start.size() == 2) ? 32'(tx_start[1] - tx_start[0]) : 32'h0,
              32'(10 * BITC));
    check_tx("tx_pair");

    // Overfill TX: one byte in the shifter plus TXD queued, the rest dropped
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < TXD + 2; k++) begin
        b = 8'($urandom);
        bus_write(2'd0, {24'($urandom), b});
        if (k < TXD + 1) tx_exp.push_back(b);
      end
      bus_read(2'd1, d); check_val($sformatf("tx_full_r%0d", r), {31'h0, d[2]}, 32'h1);
      wait_tx_idle($sformatf("tx_idle_r%0d", r));
      check_tx($sformatf("tx_burst_r%0d", r));
    end

    // Divider below 3 behaves as 3
    bus_write(2'd2, 32'd1);
    bus_read(2'd2, d); check_val("divider_low_rb", d, 32'd1);
    b = 8'($urandom);
    bus_write(2'd0, 32'(b)); tx_exp.push_back(b);
    wait_tx_idle("tx_idle_div1");
    check_tx("tx_div1");
    bus_write(2'd2, 32'd3);

    // TX flush: the byte in the shifter completes, queued bytes vanish
    b = 8'($urandom);
    bus_write(2'd0, 32'(b)); tx_exp.push_back(b);
    bus_write(2'd0, 32'($urandom));
    bus_write(2'd0, 32'($urandom));
    bus_write(2'd3, 32'h1);
    wait_tx_idle("tx_idle_flush");
    check_tx("tx_flush");

    // Five RX frames without reading: FIFO fills, fifth sets overrun
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    bus_read(2'd1, d); check_val("rx_full_status", d, exp_status());
    check_val("rx_full_irq", {31'h0, irq}, 32'h1);
    for (int k = 0; k < RXD; k++) begin
      bus_read(2'd0, d);
      check_val($sformatf("rx_read%0d", k), {24'h0, d[31], d[6:0]},
                {24'h0, 1'b0, rx_q[0][6:0]});
      void'(rx_q.pop_front());
    end
    bus_read(2'd0, d); check_val("rx_empty_bit31", {31'h0, d[31]}, 32'h1);
    bus_write(2'd1, 32'h10); m_overrun = 1'b0;
    bus_read(2'd1, d); check_val("overrun_clear", d, exp_status());
    check_val("irq_after_clear", {31'h0, irq}, 32'h0);

    // Random RX bytes, three queued for flow control
    for (int k = 0; k < 3; k++) send_frame(8'($urandom), 1'b1);
    check_val("rts_three_queued", {31'h0, rts}, {31'h0, RTS_ON});
    bus_read(2'd0, d);
    check_val("rx_rand0", d, {24'h0, rx_q[0]}); void'(rx_q.pop_front());
    @(negedge clk); @(negedge clk);
    check_val("rts_after_read", {31'h0, rts}, 32'h0);
    while (rx_q.size() != 0) begin
      bus_read(2'd0, d);
      check_val("rx_rand", d, {24'h0, rx_q[0]}); void'(rx_q.pop_front());
    end

    // RX flush
    send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b1);
    bus_write(2'd3, 32'h2); rx_q.delete();
    bus_read(2'd1, d); check_val("rx_flush_status", d, exp_status());

    // Framing error on 0x3C
    send_frame(8'h3C, 1'b0);
    bus_read(2'd1, d); check_val("framing_status", d, exp_status());
    check_val("framing_irq", {31'h0, irq}, 32'h1);
    bus_write(2'd1, 32'h20); m_framing = 1'b0;
    bus_read(2'd1, d); check_val("framing_clear", d, exp_status());
    check_val("framing_irq_clear", {31'h0, irq}, 32'h0);

    // Quarter-bit glitch must not produce a byte
    @(posedge clk); #1 rxd = 1'b0;
    @(posedge clk); #1 rxd = 1'b1;
    repeat (12 * BITC) @(posedge clk);
    bus_read(2'd1, d); check_val("glitch_ignored", d, exp_status());

    // Reset in the middle of a transmitted frame
    bus_write(2'd0, 32'h00);
    repeat (12) @(negedge clk);
    #3 rstn = 1'b0;
    #1 check_val("midframe_rst_txd", {31'h0, txd}, 32'h1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bus_read(2'd2, d); check_val("midframe_rst_div", d, 32'd554);
    bus_read(2'd1, d); check_val("midframe_rst_status", d, 32'h0);
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
